subleq_mc_core: RTL and testbench
=================================

// Module: subleq_mc_core
// PURPOSE
//  Multi-cycle, parametrised SUBLEQ processor core with sync reset and valid/ready stream I/O.
//  Fetches {op,a,b,c} from an external combinational instruction ROM.
//  Executes against an internal sync-read data RAM and stalls cleanly on I/O back-pressure.
//  Halts on a taken self-jump.
//  Sits between the program ROM and the board-level I/O streams; replaces the single-cycle core.
// PARAMETERS
//  DATA_W   8  data word width (>= ADDR_W); two's complement
//  ADDR_W   8  data RAM address width; depth = 2**ADDR_W
//  IADDR_W  8  PC / jump-target width; instruction ROM depth = 2**IADDR_W
// PORTS
//  clk        in   1                      clock, rising edge
//  rst        in   1                      synchronous, active-high reset
//  imem_addr  out  IADDR_W                instruction address (= PC)
//  imem_data  in   2+2*ADDR_W+IADDR_W     instruction {op[1:0], a, b, c}, combinational from imem_addr
//  in_data    in   DATA_W                 input stream data
//  in_valid   in   1                      input stream valid
//  in_ready   out  1                      core accepts in_data this cycle
//  out_data   out  DATA_W                 output stream data (registered)
//  out_valid  out  1                      out_data valid
//  out_ready  in   1                      sink accepts out_data
//  halted     out  1                      core stopped in HALT
// BEHAVIOUR
//  Opcodes:
//   00 SUB: r = M[b]-M[a]; M[b] <= r; branch on r
//   01 IMM: r = M[a]-sext(b); M[a] <= r; branch on r
//   10 IN:  r = in_data; M[b] <= r; branch on r
//   11 OUT: out_data <= M[a]; PC <= PC+1 (never branches)
//  Branch: PC <= c if cond(r), else PC+1 (IADDR_W wrap, 2**IADDR_W-1 -> 0). Arithmetic mod 2**DATA_W.
//  FSM states: FETCH -> RD_A -> RD_B -> EXEC -> FETCH; IN: RD_B -> WAIT_IN; OUT: RD_A -> WAIT_OUT.
//   FETCH:    IR <= imem_data; RAM addr a issued
//   RD_A:     A <= ram_q; RAM addr b issued
//   RD_B:     B <= ram_q
//   EXEC:     write RAM, update PC
//   WAIT_IN:  in_ready=1; on in_valid&in_ready write M[b], update PC, -> FETCH; holds indefinitely
//   WAIT_OUT: out_valid=1, out_data stable; on out_ready -> FETCH with PC+1
//  Latency: SUB/IMM exactly 4 cycles. IN 4 cycles + wait. OUT 3 cycles + wait (min 1 cycle in WAIT_OUT).
//  Halt: taken branch with c == PC -> HALT; halted=1; no RAM writes; exit only via rst.
//  in_ready is high only in WAIT_IN; out_valid is high only in WAIT_OUT.
//  Reset values: PC=0, state=FETCH, out_valid=0, out_data=0, in_ready=0, halted=0.
//  Reset mid-operation: any state -> FETCH next cycle. Pending out_valid dropped; no RAM write that cycle.
//  RAM contents are not cleared by reset.
//  Read-after-write: next instruction's read of just-written M[x] returns the new value (write in EXEC precedes FETCH).
//  IN with a == b: only M[b] is written.
// CONFIGURATION
//  SUBLEQ_LEQ_EN defined: cond(r) = (signed r <= 0), i.e. classic SUBLEQ.
//  SUBLEQ_LEQ_EN undefined: cond(r) = (r == 0), the legacy branch-on-zero semantics.
// STRUCTURE
//  Package subleq_pkg: op codes, FSM state enum, instruction field offset/width localparams,
//   and the branch-condition function.
//  Sub-module subleq_dmem: sync-read, sync-write single-port RAM (DATA_W x 2**ADDR_W), no reset.
//  FSM, PC, IR, A/B registers and stream handshakes live in subleq_mc_core.
// TESTING
//  1. rst for 2 cycles mid-WAIT_OUT -> out_valid=0, PC=0, state FETCH on the cycle after rst falls.
//  2. M[1]=5, M[2]=5, SUB a=1 b=2 c=7 -> M[2]=0, PC=7 after exactly 4 cycles.
//  3. M[1]=3, M[2]=1, SUB a=1 b=2 c=9 -> M[2]=8'hFE.
//     With SUBLEQ_LEQ_EN: PC=9. Without: PC=PC+1.
//  4. IN b=4 with in_valid low for 10 cycles, then in_data=8'h2A -> in_ready held high throughout,
//     M[4]=8'h2A on accept, PC+1.
//  5. M[3]=8'h55, OUT a=3 with out_ready low for 6 cycles -> out_data=8'h55 and out_valid stable throughout,
//     PC+1 after handshake.
//  6. IMM a=0 b=0 c=PC at PC=8'hFF -> taken self-jump, halted=1, no further imem_addr change.
//     A not-taken branch at PC=8'hFF wraps PC to 0.

Source files
------------

// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - opcodes, FSM states, instruction layout helpers and branch rule (SUBLEQ_LEQ_EN)
package subleq_pkg;

    localparam int OP_W   = 2;
    localparam int COND_W = 64;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_IMM = 2'b01,
        OP_IN  = 2'b10,
        OP_OUT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_WAIT_IN,
        ST_WAIT_OUT,
        ST_HALT
    } state_e;

    // Instruction word is {op, a, b, c} with c in the least significant bits.
    function automatic int instr_width(input int addr_w, input int iaddr_w);
        return OP_W + 2 * addr_w + iaddr_w;
    endfunction

    function automatic int field_c_lsb();
        return 0;
    endfunction

    function automatic int field_b_lsb(input int iaddr_w);
        return iaddr_w;
    endfunction

    function automatic int field_a_lsb(input int addr_w, input int iaddr_w);
        return iaddr_w + addr_w;
    endfunction

    function automatic int field_op_lsb(input int addr_w, input int iaddr_w);
        return iaddr_w + 2 * addr_w;
    endfunction

    // Caller sign-extends the result to COND_W so one function serves any DATA_W.
    function automatic logic branch_taken(input logic signed [COND_W-1:0] r);
`ifdef SUBLEQ_LEQ_EN
        return r <= 0;
`else
        return r == 0;
`endif
    endfunction

endpackage

// File: rtl/subleq_dmem.sv
// rtl/subleq_dmem.sv - single-port data RAM, synchronous read and write, contents not reset
module subleq_dmem
    import subleq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write-first is not needed: the core never reads the address it writes in the same cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/subleq_mc_core.sv
// rtl/subleq_mc_core.sv - multi-cycle SUBLEQ core with stream I/O; branch rule set by SUBLEQ_LEQ_EN
module subleq_mc_core
    import subleq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int IADDR_W = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [IADDR_W-1:0]                imem_addr,
    input  logic [2+2*ADDR_W+IADDR_W-1:0]     imem_data,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              halted
);

    localparam int INSTR_W = instr_width(ADDR_W, IADDR_W);
    localparam int C_LSB   = field_c_lsb();
    localparam int B_LSB   = field_b_lsb(IADDR_W);
    localparam int A_LSB   = field_a_lsb(ADDR_W, IADDR_W);
    localparam int OP_LSB  = field_op_lsb(ADDR_W, IADDR_W);

    state_e               state;
    logic [IADDR_W-1:0]   pc;
    logic [INSTR_W-1:0]   ir;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;

    op_e                  ir_op;
    logic [ADDR_W-1:0]    ir_a;
    logic [ADDR_W-1:0]    ir_b;
    logic [IADDR_W-1:0]   ir_c;
    logic [ADDR_W-1:0]    fetch_a;
    logic signed [ADDR_W-1:0] imm_s;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    exec_r;
    logic [IADDR_W-1:0]   pc_inc;
    logic                 br_take;

    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_d;
    logic [DATA_W-1:0]    ram_q;
    logic                 ram_we;

    assign imem_addr = pc;
    assign ir_op     = op_e'(ir[OP_LSB +: OP_W]);
    assign ir_a      = ir[A_LSB +: ADDR_W];
    assign ir_b      = ir[B_LSB +: ADDR_W];
    assign ir_c      = ir[C_LSB +: IADDR_W];
    assign fetch_a   = imem_data[A_LSB +: ADDR_W];
    assign imm_s     = signed'(ir_b);
    assign imm_ext   = DATA_W'(imm_s);
    assign exec_r    = (ir_op == OP_IMM) ? (a_q - imm_ext) : (b_q - a_q);
    assign pc_inc    = pc + IADDR_W'(1);

    // Branch decision for whichever state commits a result: EXEC uses the ALU, WAIT_IN the stream word.
    always_comb begin
        br_take = 1'b0;
        if (state == ST_EXEC) begin
            br_take = branch_taken(COND_W'(signed'(exec_r)));
        end else if (state == ST_WAIT_IN) begin
            br_take = branch_taken(COND_W'(signed'(in_data)));
        end
    end

    // RAM port steering: read a during FETCH, b during RD_A, write the destination on commit.
    always_comb begin
        ram_addr = ir_a;
        ram_d    = exec_r;
        ram_we   = 1'b0;
        case (state)
            ST_FETCH:   ram_addr = fetch_a;
            ST_RD_A:    ram_addr = ir_b;
            ST_EXEC: begin
                ram_addr = (ir_op == OP_IMM) ? ir_a : ir_b;
                ram_we   = 1'b1;
            end
            ST_WAIT_IN: begin
                ram_addr = ir_b;
                ram_d    = in_data;
                ram_we   = in_valid;
            end
            default: ;
        endcase
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    subleq_dmem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

    // Main sequencer: instruction phases, PC update, halt detection and registered stream handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= imem_data;
                    state <= ST_RD_A;
                end
                ST_RD_A: begin
                    a_q <= ram_q;
                    if (ir_op == OP_OUT) begin
                        out_data  <= ram_q;
                        out_valid <= 1'b1;
                        state     <= ST_WAIT_OUT;
                    end else begin
                        state <= ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    b_q <= ram_q;
                    if (ir_op == OP_IN) begin
                        in_ready <= 1'b1;
                        state    <= ST_WAIT_IN;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC, ST_WAIT_IN: begin
                    if (state == ST_EXEC || in_valid) begin
                        in_ready <= 1'b0;
                        if (br_take && ir_c == pc) begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            pc    <= br_take ? ir_c : pc_inc;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_mc_core.sv
// tb/tb_subleq_mc_core.sv - directed and randomized checks of subleq_mc_core against a behavioural model
module tb_subleq_mc_core;

    localparam int DW      = 8;
    localparam int AW      = 8;
    localparam int IW      = 8;
    localparam int INSTR_W = 2 + 2 * AW + IW;
    localparam int NCELL   = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [IW-1:0]      imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [DW-1:0]      in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               halted;

    logic [INSTR_W-1:0] rom [256];
    assign imem_data = rom[imem_addr];

    subleq_mc_core #(.DATA_W(DW), .ADDR_W(AW), .IADDR_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [INSTR_W-1:0] enc(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    // Stimulus: queued input words, acceptance probabilities.
    logic [7:0] feed_q [$];
    int in_pct    = 100;
    int out_pct   = 100;
    bit rand_mode = 0;

    always @(negedge clk) begin
        if (rand_mode && feed_q.size() == 0) feed_q.push_back(8'($urandom));
        if (feed_q.size() > 0 && $urandom_range(99) < in_pct) begin
            in_valid = 1'b1;
            in_data  = feed_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        out_ready = ($urandom_range(99) < out_pct);
    end

    // Behavioural model: instruction-level semantics plus per-opcode cycle counts.
    logic [7:0] m_mem [256];
    logic [7:0] m_pc;
    int         m_k;
    bit         m_halted;
    bit         m_ov;
    logic [7:0] m_od;

    function automatic bit cond(input logic [7:0] r);
`ifdef SUBLEQ_LEQ_EN
        return $signed(r) <= 0;
`else
        return r == 0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [1:0] op;
        logic [7:0] fa, fb, fc, r;
        bit         commit;
        bit         exp_ir;
        commit = 0;
        r      = '0;
        if (rst) begin
            m_pc = 0; m_k = 0; m_halted = 0; m_ov = 0; m_od = 0;
        end else if (!m_halted) begin
            {op, fa, fb, fc} = rom[m_pc];
            case (op)
                2'd0, 2'd1: begin
                    if (m_k == 3) begin
                        if (op == 2'd0) begin
                            r = m_mem[fb] - m_mem[fa];
                            m_mem[fb] = r;
                        end else begin
                            r = m_mem[fa] - fb;
                            m_mem[fa] = r;
                        end
                        commit = 1;
                    end else m_k++;
                end
                2'd2: begin
                    if (m_k == 3) begin
                        if (in_valid) begin
                            r = in_data;
                            m_mem[fb] = r;
                            commit = 1;
                            if (feed_q.size() > 0) void'(feed_q.pop_front());
                        end
                    end else m_k++;
                end
                default: begin
                    if (m_k == 1) begin
                        m_ov = 1; m_od = m_mem[fa]; m_k = 2;
                    end else if (m_k == 2) begin
                        if (out_ready) begin
                            m_ov = 0; m_pc = m_pc + 8'd1; m_k = 0;
                        end
                    end else m_k++;
                end
            endcase
            if (commit) begin
                m_k = 0;
                if (cond(r)) begin
                    if (fc == m_pc) m_halted = 1;
                    else m_pc = fc;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
        end
        #1;
        exp_ir = !m_halted && (rom[m_pc][INSTR_W-1 -: 2] == 2'd2) && (m_k == 3);
        check("cmp_pc", 32'(imem_addr), 32'(m_pc));
        check("cmp_in_ready", 32'(in_ready), 32'(exp_ir));
        check("cmp_out_valid", 32'(out_valid), 32'(m_ov));
        check("cmp_out_data", 32'(out_data), 32'(m_od));
        check("cmp_halted", 32'(halted), 32'(m_halted));
    end

    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b1;
        feed_q.delete();
        for (int i = 0; i < 256; i++) rom[i] = enc(2'd0, 8'd5, 8'd5, 8'(i));
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                           input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5);
        for (int i = 0; i < NCELL; i++) rom[i] = enc(2'd2, 8'd0, 8'(i), 8'(i + 1));
        feed_q.push_back(v0); feed_q.push_back(v1); feed_q.push_back(v2);
        feed_q.push_back(v3); feed_q.push_back(v4); feed_q.push_back(v5);
    endtask

    task automatic wait_pc(input logic [7:0] t, input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (imem_addr === t);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_out(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (out_valid === 1'b1);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        // OUT held by back-pressure: data and valid stable, then PC+1.
        begin_prog();
        preload(8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00);
        rom[6] = enc(2'd3, 8'd3, 8'd0, 8'd0);
        out_pct = 0;
        release_rst();
        wait_out("t5_reach_out");
        for (int i = 0; i < 6; i++) begin
            check("t5_hold_data", 32'(out_data), 32'h55);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_pct = 100;
        wait_pc(8'd7, "t5_pc_after");

        // Reset during WAIT_OUT.
        begin_prog();
        preload(8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00);
        rom[6] = enc(2'd3, 8'd3, 8'd0, 8'd0);
        out_pct = 0;
        release_rst();
        wait_out("t1_reach_out");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_out_data", 32'(out_data), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        check("t1_pc", 32'(imem_addr), 32'd0);
        out_pct = 100;

        // SUB to zero: taken, PC=7 exactly 4 cycles after fetch.
        begin_prog();
        preload(8'h00, 8'd5, 8'd5, 8'h00, 8'h00, 8'h00);
        rom[6] = enc(2'd0, 8'd1, 8'd2, 8'd7);
        rom[7] = enc(2'd3, 8'd2, 8'd0, 8'd0);
        release_rst();
        wait_pc(8'd6, "t2_reach");
        repeat (3) @(negedge clk);
        check("t2_pc_cycle3", 32'(imem_addr), 32'd6);
        @(negedge clk);
        check("t2_pc_cycle4", 32'(imem_addr), 32'd7);
        wait_out("t2_reach_out");
        check("t2_m2", 32'(out_data), 32'h00);

        // SUB to negative: branch depends on build option.
        begin_prog();
        preload(8'h00, 8'd3, 8'd1, 8'h00, 8'h00, 8'h00);
        rom[6] = enc(2'd0, 8'd1, 8'd2, 8'd9);
        rom[7] = enc(2'd3, 8'd2, 8'd0, 8'd0);
        rom[9] = enc(2'd3, 8'd2, 8'd0, 8'd0);
        release_rst();
        wait_pc(8'd6, "t3_reach");
        repeat (4) @(negedge clk);
`ifdef SUBLEQ_LEQ_EN
        check("t3_pc", 32'(imem_addr), 32'd9);
`else
        check("t3_pc", 32'(imem_addr), 32'd7);
`endif
        wait_out("t3_reach_out");
        check("t3_m2", 32'(out_data), 32'hFE);

        // IN with a starved source for 10 cycles.
        begin_prog();
        preload(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rom[6] = enc(2'd2, 8'd0, 8'd4, 8'h20);
        rom[7] = enc(2'd3, 8'd4, 8'd0, 8'd0);
        release_rst();
        wait_pc(8'd6, "t4_reach");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t4_in_ready_hold", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        feed_q.push_back(8'h2A);
        wait_pc(8'd7, "t4_pc_after");
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        wait_out("t4_reach_out");
        check("t4_m4", 32'(out_data), 32'h2A);

        // Taken self-jump at PC=FF halts.
        begin_prog();
        preload(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rom[6]   = enc(2'd1, 8'd5, 8'd0, 8'hFF);
        rom[255] = enc(2'd1, 8'd0, 8'd0, 8'hFF);
        release_rst();
        wait_pc(8'hFF, "t6_reach");
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t6_halted", 32'(halted), 32'd1);
            check("t6_pc_frozen", 32'(imem_addr), 32'hFF);
            @(negedge clk);
        end

        // Not-taken branch at PC=FF wraps to 0.
        begin_prog();
        preload(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rom[6]   = enc(2'd1, 8'd5, 8'd0, 8'hFF);
        rom[255] = enc(2'd1, 8'd0, 8'd0, 8'h10);
        release_rst();
        wait_pc(8'hFF, "t6w_reach");
        repeat (4) @(negedge clk);
        check("t6w_pc_wrap", 32'(imem_addr), 32'd0);
        check("t6w_not_halted", 32'(halted), 32'd0);

        // Random programs with random back-pressure and reset pulses.
        rand_mode = 1;
        in_pct    = 60;
        out_pct   = 50;
        for (int p = 0; p < 20; p++) begin
            begin_prog();
            preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            for (int pc = NCELL; pc < 256; pc++) begin
                logic [1:0] op;
                logic [7:0] a, b, c;
                op = 2'($urandom_range(3));
                a  = 8'($urandom_range(NCELL - 1));
                b  = (op == 2'd1) ? 8'($urandom) : 8'($urandom_range(NCELL - 1));
                c  = ($urandom_range(15) == 0) ? 8'(pc) : 8'($urandom);
                rom[pc] = enc(op, a, b, c);
            end
            release_rst();
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                if (rst) rst = 1'b0;
                else if ($urandom_range(199) == 0) rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
